// File: rtl/game_pkg.sv
//------------------------------------------------------------------------------
// Module : game_pkg
// Brief  : Shared types and board-geometry constants for the game referee.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package game_pkg;

  localparam int CELL_W    = 2;
  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    EVAL = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int LINE_ROW0 = 0;
  localparam int LINE_ROW1 = 1;
  localparam int LINE_ROW2 = 2;
  localparam int LINE_COL0 = 3;
  localparam int LINE_COL1 = 4;
  localparam int LINE_COL2 = 5;
  localparam int LINE_DIAG = 6;
  localparam int LINE_ANTI = 7;

  // Cell numbers are 1-based, in the same order as the win_line bits.
  localparam int LINE_CELL [NUM_LINES][3] = '{
    '{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9},
    '{1, 4, 7}, '{2, 5, 8}, '{3, 6, 9},
    '{1, 5, 9}, '{3, 5, 7}
  };

  function automatic int cell_lsb(input int k);
    return CELL_W * (k - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_referee_line_checker.sv
//------------------------------------------------------------------------------
// Module : line_checker
// Brief  : Flags a line of three cells all occupied by the same owner.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module line_checker
  import game_pkg::*;
(
  input  logic [CELL_W-1:0] i_a,
  input  logic [CELL_W-1:0] i_b,
  input  logic [CELL_W-1:0] i_c,
  output logic              o_complete,
  output logic              o_owner
);

  logic w_occupied;
  logic w_same_owner;

  assign w_occupied   = i_a[1] & i_b[1] & i_c[1];
  assign w_same_owner = (i_a[0] == i_b[0]) && (i_b[0] == i_c[0]);
  assign o_complete   = w_occupied & w_same_owner;
  assign o_owner      = i_a[0];

endmodule

`default_nettype wire

// File: rtl/game_referee.sv
//------------------------------------------------------------------------------
// Module : game_referee
// Brief  : Turn keeper, move counter and win/draw judge for a 3x3 board.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module game_referee
  import game_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0,
  parameter int   MAX_MOVES    = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CELLS*CELL_W-1:0]   i_cells,
  input  logic                          i_move_made,
  output logic                          o_player,
  output logic                          o_board_lock,
  output logic [3:0]                    o_move_count,
  output logic                          o_game_over,
  output logic                          o_winner_valid,
  output logic                          o_winner,
  output logic                          o_draw,
  output logic [NUM_LINES-1:0]          o_win_line,
  output logic                          o_protocol_err
);

  localparam logic [3:0] c_max_count = 4'(MAX_MOVES);

  state_t                 r_state;
  logic                   r_player;
  logic [3:0]             r_move_count;
  logic                   r_winner_valid;
  logic                   r_winner;
  logic                   r_draw;
  logic [NUM_LINES-1:0]   r_win_line;
  logic                   r_protocol_err;

  logic [NUM_LINES-1:0]   w_complete;
  logic [NUM_LINES-1:0]   w_owner;
  logic                   w_win_owner;

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_lines
    line_checker u_line (
      .i_a        (i_cells[cell_lsb(LINE_CELL[l][0]) +: CELL_W]),
      .i_b        (i_cells[cell_lsb(LINE_CELL[l][1]) +: CELL_W]),
      .i_c        (i_cells[cell_lsb(LINE_CELL[l][2]) +: CELL_W]),
      .o_complete (w_complete[l]),
      .o_owner    (w_owner[l])
    );
  end

  // Lines closed by one move all contain that move's cell, so they share an owner.
  assign w_win_owner = |(w_complete & w_owner);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= PLAY;
      r_player       <= FIRST_PLAYER;
      r_move_count   <= 4'd0;
      r_winner_valid <= 1'b0;
      r_winner       <= 1'b0;
      r_draw         <= 1'b0;
      r_win_line     <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          if (i_move_made) begin
            r_state  <= EVAL;
            r_player <= ~r_player;
            if (r_move_count != c_max_count) begin
              r_move_count <= r_move_count + 4'd1;
            end
          end
        end
        EVAL: begin
          if (i_move_made) begin
            r_protocol_err <= 1'b1;
          end
          if (|w_complete) begin
            r_state        <= OVER;
            r_winner_valid <= 1'b1;
            r_winner       <= w_win_owner;
            r_win_line     <= w_complete;
          end else if (r_move_count == c_max_count) begin
            r_state <= OVER;
            r_draw  <= 1'b1;
          end else begin
            r_state <= PLAY;
          end
        end
        OVER: begin
          if (i_move_made) begin
            r_protocol_err <= 1'b1;
          end
        end
        default: r_state <= PLAY;
      endcase
    end
  end

  assign o_player       = r_player;
  assign o_board_lock   = (r_state != PLAY);
  assign o_move_count   = r_move_count;
  assign o_game_over    = (r_state == OVER);
  assign o_winner_valid = r_winner_valid;
  assign o_winner       = r_winner;
  assign o_draw         = r_draw;
  assign o_win_line     = r_win_line;
  assign o_protocol_err = r_protocol_err;

endmodule

`default_nettype wire

// File: tb/tb_game_referee.sv
//------------------------------------------------------------------------------
// Module : tb_game_referee
// Brief  : Directed self-checking bench for game_referee.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_game_referee;

  logic        clk;
  logic        rst;
  logic [17:0] cells;
  logic        move_made;
  logic        player;
  logic        board_lock;
  logic [3:0]  move_count;
  logic        game_over;
  logic        winner_valid;
  logic        winner;
  logic        draw;
  logic [7:0]  win_line;
  logic        protocol_err;

  int total;
  int bad;

  game_referee #(.FIRST_PLAYER(1'b0), .MAX_MOVES(9)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_cells        (cells),
    .i_move_made    (move_made),
    .o_player       (player),
    .o_board_lock   (board_lock),
    .o_move_count   (move_count),
    .o_game_over    (game_over),
    .o_winner_valid (winner_valid),
    .o_winner       (winner),
    .o_draw         (draw),
    .o_win_line     (win_line),
    .o_protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b1;
    cells     = '0;
    move_made = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Writes cell k for 'who' and pulses move_made across one rising edge; returns
  // 1ns after that edge, i.e. with the referee in EVAL.
  task automatic pulse_move(input int k, input logic who);
    @(negedge clk);
    cells[2*(k-1) +: 2] = {1'b1, who};
    move_made = 1'b1;
    @(posedge clk);
    #1;
    move_made = 1'b0;
  endtask

  // Plays n moves alternating owners from player 0; returns 1ns after the
  // evaluation edge of the last move.
  task automatic play_seq(input int seq[9], input int n);
    for (int i = 0; i < n; i++) begin
      pulse_move(seq[i], logic'(i % 2));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cells = '0; move_made = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (player !== 1'b0) begin bad++; $display("FAIL reset_player got=%0b exp=0", player); end
    total++; if (move_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", move_count); end
    total++; if (board_lock !== 1'b0) begin bad++; $display("FAIL reset_lock got=%0b exp=0", board_lock); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_over got=%0b exp=0", game_over); end
    total++; if (win_line !== 8'h00) begin bad++; $display("FAIL reset_winline got=%0h exp=00", win_line); end
    total++; if ({winner_valid, winner, draw, protocol_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%0b exp=0000", {winner_valid, winner, draw, protocol_err});
    end
  endtask

  task automatic test_row_win();
    int seq[9] = '{1, 4, 2, 5, 3, 0, 0, 0, 0};
    apply_reset();
    play_seq(seq, 4);
    total++; if (move_count !== 4'd4) begin bad++; $display("FAIL row_count4 got=%0d exp=4", move_count); end
    total++; if (board_lock !== 1'b0) begin bad++; $display("FAIL row_unlocked got=%0b exp=0", board_lock); end
    pulse_move(3, 1'b0);
    total++; if ({board_lock, game_over} !== 2'b10) begin
      bad++; $display("FAIL row_eval lock/over got=%0b exp=10", {board_lock, game_over});
    end
    @(posedge clk);
    #1;
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL row_over got=%0b exp=1", game_over); end
    total++; if (winner_valid !== 1'b1) begin bad++; $display("FAIL row_wvalid got=%0b exp=1", winner_valid); end
    total++; if (winner !== 1'b0) begin bad++; $display("FAIL row_winner got=%0b exp=0", winner); end
    total++; if (win_line !== 8'h01) begin bad++; $display("FAIL row_winline got=%0h exp=01", win_line); end
    total++; if (move_count !== 4'd5) begin bad++; $display("FAIL row_count got=%0d exp=5", move_count); end
    total++; if ({draw, player} !== 2'b01) begin bad++; $display("FAIL row_draw_player got=%0b exp=01", {draw, player}); end
  endtask

  task automatic test_draw();
    int seq[9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    apply_reset();
    play_seq(seq, 8);
    total++; if ({game_over, board_lock} !== 2'b00) begin
      bad++; $display("FAIL draw_pre9 over/lock got=%0b exp=00", {game_over, board_lock});
    end
    play_seq('{9, 0, 0, 0, 0, 0, 0, 0, 0}, 1);
    total++; if (draw !== 1'b1) begin bad++; $display("FAIL draw_flag got=%0b exp=1", draw); end
    total++; if (winner_valid !== 1'b0) begin bad++; $display("FAIL draw_wvalid got=%0b exp=0", winner_valid); end
    total++; if (win_line !== 8'h00) begin bad++; $display("FAIL draw_winline got=%0h exp=00", win_line); end
    total++; if (move_count !== 4'd9) begin bad++; $display("FAIL draw_count got=%0d exp=9", move_count); end
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL draw_over got=%0b exp=1", game_over); end
  endtask

  task automatic test_double_line();
    int seq[9] = '{7, 1, 8, 2, 3, 4, 6, 5, 9};
    apply_reset();
    play_seq(seq, 9);
    total++; if (win_line !== 8'h24) begin bad++; $display("FAIL dbl_winline got=%0h exp=24", win_line); end
    total++; if (winner_valid !== 1'b1) begin bad++; $display("FAIL dbl_wvalid got=%0b exp=1", winner_valid); end
    total++; if ({winner, draw} !== 2'b00) begin bad++; $display("FAIL dbl_winner_draw got=%0b exp=00", {winner, draw}); end
    total++; if (move_count !== 4'd9) begin bad++; $display("FAIL dbl_count got=%0d exp=9", move_count); end
  endtask

  task automatic test_protocol();
    apply_reset();
    pulse_move(1, 1'b0);
    // Hold move_made high over the EVAL edge.
    move_made = 1'b1;
    total++; if (board_lock !== 1'b1) begin bad++; $display("FAIL prot_eval_lock got=%0b exp=1", board_lock); end
    @(posedge clk);
    #1;
    move_made = 1'b0;
    total++; if (move_count !== 4'd1) begin bad++; $display("FAIL prot_eval_count got=%0d exp=1", move_count); end
    total++; if (player !== 1'b1) begin bad++; $display("FAIL prot_eval_player got=%0b exp=1", player); end
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL prot_eval_err got=%0b exp=1", protocol_err); end
    play_seq('{4, 0, 0, 0, 0, 0, 0, 0, 0}, 0);
    pulse_move(4, 1'b1); @(posedge clk); #1;
    pulse_move(2, 1'b0); @(posedge clk); #1;
    pulse_move(5, 1'b1); @(posedge clk); #1;
    pulse_move(3, 1'b0); @(posedge clk); #1;
    total++; if ({game_over, protocol_err} !== 2'b11) begin
      bad++; $display("FAIL prot_sticky over/err got=%0b exp=11", {game_over, protocol_err});
    end
    @(negedge clk);
    move_made = 1'b1;
    @(posedge clk);
    #1;
    move_made = 1'b0;
    @(posedge clk);
    #1;
    total++; if (move_count !== 4'd5) begin bad++; $display("FAIL prot_over_count got=%0d exp=5", move_count); end
    total++; if (player !== 1'b1) begin bad++; $display("FAIL prot_over_player got=%0b exp=1", player); end
    total++; if ({board_lock, game_over, protocol_err} !== 3'b111) begin
      bad++; $display("FAIL prot_over_flags got=%0b exp=111", {board_lock, game_over, protocol_err});
    end
  endtask

  task automatic test_reset_mid_game();
    apply_reset();
    pulse_move(1, 1'b0);
    move_made = 1'b1;
    @(posedge clk);
    #1;
    move_made = 1'b0;
    pulse_move(5, 1'b1); @(posedge clk); #1;
    pulse_move(9, 1'b0);
    total++; if ({board_lock, move_count, protocol_err} !== {1'b1, 4'd3, 1'b1}) begin
      bad++; $display("FAIL mid_pre got=%0b exp=1_0011_1", {board_lock, move_count, protocol_err});
    end
    #1;
    rst = 1'b1;
    #1;
    total++; if (board_lock !== 1'b0) begin bad++; $display("FAIL mid_lock got=%0b exp=0", board_lock); end
    total++; if (move_count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", move_count); end
    total++; if (player !== 1'b0) begin bad++; $display("FAIL mid_player got=%0b exp=0", player); end
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%0b exp=0", protocol_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    cells     = '0;
    move_made = 1'b0;
    test_reset();
    test_row_win();
    test_draw();
    test_double_line();
    test_protocol();
    test_reset_mid_game();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
